taadda_sequencer: RTL and testbench

TAADDA_SEQUENCER -- requirements
Module: taadda_sequencer

---
 rtl/taadda_pkg.sv | 47 ++++
 rtl/taadda_alu.sv | 42 ++++
 rtl/taadda_sequencer.sv | 150 +++++++++++++++
 tb/tb_taadda_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taadda_pkg.sv
// Shared types and encodings for the taadda instruction sequencer.
package taadda_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_EXEC     = 3'd2,
    ST_OUT_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  // Operand source codes (0-5 select r0-r5)
  localparam logic [2:0] SRC_PC  = 3'd6;
  localparam logic [2:0] SRC_IN  = 3'd7;

  // Destination codes (0-5 select r0-r5)
  localparam logic [2:0] DST_PC  = 3'd6;
  localparam logic [2:0] DST_OUT = 3'd7;

  // Opcode flag bit positions
  localparam int OP_IMM1_BIT = 7;
  localparam int OP_IMM2_BIT = 6;
  localparam int OP_JMP_BIT  = 5;

  // ALU operations (opcode bits [2:0] when not a jump)
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_NOT  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  // Jump conditions, unsigned compare of arg1 against arg2
  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_LE     = 3'd3;
  localparam logic [2:0] COND_GT     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/taadda_alu.sv
// Combinational ALU and unsigned comparator shared by ALU and jump opcodes.
module taadda_alu
  import taadda_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       cond_true
);

  // Arithmetic wraps modulo 256; the carry is simply dropped.
  always_comb begin
    result = 8'h00;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NOT:  result = ~a;
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
    endcase
  end

  // Same op field read as a branch condition.
  always_comb begin
    cond_true = 1'b0;
    case (op)
      COND_EQ:     cond_true = (a == b);
      COND_NE:     cond_true = (a != b);
      COND_LT:     cond_true = (a <  b);
      COND_LE:     cond_true = (a <= b);
      COND_GT:     cond_true = (a >  b);
      COND_GE:     cond_true = (a >= b);
      COND_ALWAYS: cond_true = 1'b1;
      COND_NEVER:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/taadda_sequencer.sv
// Tiny fetch/execute sequencer: fetches 32-bit instructions, runs them through
// the ALU, and moves bytes between an external register file and I/O ports.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never waits for ready and, once raised, holds its data
// stable until the transfer. in_ready is only raised together with in_valid
// in the executing cycle, so it pulses exactly once per consumed byte.
module taadda_sequencer
  import taadda_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [2:0]  rf_rsel_a,
  output logic [2:0]  rf_rsel_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [2:0]  rf_wsel,
  output logic [7:0]  rf_wdata,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  pc,
  output logic        halted,
  output state_e      state
);

  localparam logic [7:0] STEP = 8'(PC_STEP);

  logic [31:0] instr;
  logic [7:0]  opcode, arg1, arg2, dest;
  logic        imm1, imm2, is_jump, is_halt;
  logic [7:0]  opnd_a, opnd_b, alu_result, pc_inc;
  logic        cond_true, need_in, exec_go;

  assign opcode  = instr[7:0];
  assign arg1    = instr[15:8];
  assign arg2    = instr[23:16];
  assign dest    = instr[31:24];
  assign imm1    = opcode[OP_IMM1_BIT];
  assign imm2    = opcode[OP_IMM2_BIT];
  assign is_halt = (opcode == HALT_OPCODE);
  assign is_jump = opcode[OP_JMP_BIT];
  assign pc_inc  = pc + STEP;

  // Operand muxes: immediate, current pc, input byte, or register read data.
  always_comb begin
    opnd_a = rf_rdata_a;
    if (imm1)                      opnd_a = arg1;
    else if (arg1[2:0] == SRC_PC)  opnd_a = pc;
    else if (arg1[2:0] == SRC_IN)  opnd_a = in_data;
    opnd_b = rf_rdata_b;
    if (imm2)                      opnd_b = arg2;
    else if (arg2[2:0] == SRC_PC)  opnd_b = pc;
    else if (arg2[2:0] == SRC_IN)  opnd_b = in_data;
  end

  taadda_alu alu_i (
    .a         (opnd_a),
    .b         (opnd_b),
    .op        (opcode[2:0]),
    .result    (alu_result),
    .cond_true (cond_true)
  );

  // EXEC completes once any needed input byte is present; both operands
  // share the same byte when both name the input port.
  assign need_in  = !is_halt &&
                    ((!imm1 && arg1[2:0] == SRC_IN) || (!imm2 && arg2[2:0] == SRC_IN));
  assign exec_go  = (state == ST_EXEC) && (!need_in || in_valid);
  assign in_ready = exec_go && need_in;

  // Strobes decoded from state so they land in the FETCH/EXEC cycle itself;
  // imem_req is gated by rst so nothing is requested while held in reset.
  assign imem_req  = rst && (state == ST_FETCH);
  assign imem_addr = pc;
  assign rf_rsel_a = arg1[2:0];
  assign rf_rsel_b = arg2[2:0];
  assign rf_we     = exec_go && !is_halt && !is_jump && (dest[2:0] < DST_PC);
  assign rf_wsel   = dest[2:0];
  assign rf_wdata  = (state == ST_EXEC) ? alu_result : 8'h00;

  // Main sequencer FSM with registered pc, instruction and output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= 8'h00;
      instr     <= 32'h0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_valid) begin
            instr <= imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (exec_go) begin
            if (is_jump) begin
              pc    <= cond_true ? dest : pc_inc;
              state <= ST_FETCH;
            end else begin
              case (dest[2:0])
                DST_PC: begin
                  pc    <= alu_result;
                  state <= ST_FETCH;
                end
                DST_OUT: begin
                  out_valid <= 1'b1;
                  out_data  <= alu_result;
                  state     <= ST_OUT_WAIT;
                end
                default: begin
                  pc    <= pc_inc;
                  state <= ST_FETCH;
                end
              endcase
            end
          end
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc_inc;
            state     <= ST_FETCH;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_taadda_sequencer.sv
// Bench for taadda_sequencer: memory/register-file/IO environment plus an
// instruction-level reference model of the sequencer.
module tb_taadda_sequencer;
  import taadda_pkg::*;

  localparam int PC_STEP = 4;
  localparam int MAX_CYC = 300;

  logic        clk, rst;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [2:0]  rf_rsel_a, rf_rsel_b, rf_wsel;
  logic [7:0]  rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we, in_valid, in_ready, out_valid, out_ready, halted;
  logic [7:0]  in_data, out_data, pc;
  state_e      state;

  int checks = 0;
  int failures = 0;

  taadda_sequencer #(.PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .rf_rsel_a(rf_rsel_a), .rf_rsel_b(rf_rsel_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pc(pc), .halted(halted), .state(state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- environment ----------------
  logic [7:0]  rf [0:7];
  logic [31:0] imem [0:255];
  assign rf_rdata_a = rf[rf_rsel_a];
  assign rf_rdata_b = rf[rf_rsel_b];

  int mem_lat = 0, in_delay = 0, out_delay = 0, force_valid = 0;
  int in_fires = 0, in_ready_cycles = 0;
  logic [7:0] in_q[$];
  logic [7:0] obs_q[$];

  // Samples DUT outputs before each rising edge, applies their effect after it.
  initial begin
    logic s_req, s_we, s_in, s_irdy, s_out, s_ov;
    logic [7:0] s_addr, s_wdata, s_od, pend_addr;
    logic [2:0] s_wsel;
    bit pend;
    int pend_cnt;
    pend = 0; pend_cnt = 0; pend_addr = 0;
    imem_valid = 0; imem_data = 0; in_valid = 0; in_data = 0; out_ready = 0;
    forever begin
      @(negedge clk); #2;
      s_req = imem_req; s_addr = imem_addr; s_we = rf_we; s_wsel = rf_wsel; s_wdata = rf_wdata;
      s_in = in_valid && in_ready; s_irdy = in_ready; s_out = out_valid && out_ready;
      s_ov = out_valid; s_od = out_data;
      @(posedge clk); #1;
      if (!rst) begin
        pend = 0; imem_valid = 0; in_valid = 0; in_data = 0; out_ready = 0;
        in_q.delete();
      end else begin
        if (s_we) rf[s_wsel] = s_wdata;
        if (s_irdy) in_ready_cycles++;
        if (s_in) begin void'(in_q.pop_front()); in_fires++; end
        if (s_out) obs_q.push_back(s_od);
        imem_valid = 0;
        if (s_req) begin pend = 1; pend_cnt = mem_lat; pend_addr = s_addr; end
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (pend && pend_cnt == 0) begin imem_valid = 1; imem_data = imem[pend_addr]; pend = 0; end
        if (force_valid > 0) begin imem_valid = 1; imem_data = 32'h07_01_01_C0; force_valid--; end
        if (in_q.size() > 0 && in_delay > 0) in_delay--;
        in_valid = (in_q.size() > 0) && (in_delay == 0);
        in_data = in_valid ? in_q[0] : 8'h00;
        if (s_ov && !s_out && out_delay > 0) out_delay--;
        out_ready = (out_delay == 0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_rf [0:7];
  logic [7:0] m_pc;
  bit         m_halt;
  logic [7:0] exp_q[$];

  function automatic bit uses_input(input logic [31:0] ins);
    if (ins[7:0] == 8'hFF) return 1'b0;
    return (!ins[7] && ins[10:8] == 3'd7) || (!ins[6] && ins[18:16] == 3'd7);
  endfunction

  function automatic logic [7:0] src_val(input logic [2:0] s, input logic [7:0] inb);
    if (s == 3'd6) return m_pc;
    if (s == 3'd7) return inb;
    return m_rf[s];
  endfunction

  // Architectural effect of one instruction.
  task automatic model_exec(input logic [31:0] ins, input logic [7:0] inb);
    logic [7:0] op, a1, a2, d, va, vb, r;
    bit t;
    op = ins[7:0]; a1 = ins[15:8]; a2 = ins[23:16]; d = ins[31:24];
    if (op == 8'hFF) begin m_halt = 1; return; end
    va = op[7] ? a1 : src_val(a1[2:0], inb);
    vb = op[6] ? a2 : src_val(a2[2:0], inb);
    if (op[5]) begin
      case (op[2:0])
        3'd0: t = (va == vb);
        3'd1: t = (va != vb);
        3'd2: t = (va < vb);
        3'd3: t = (va <= vb);
        3'd4: t = (va > vb);
        3'd5: t = (va >= vb);
        3'd6: t = 1;
        default: t = 0;
      endcase
      m_pc = t ? d : m_pc + 8'(PC_STEP);
    end else begin
      case (op[2:0])
        3'd0: r = va + vb;
        3'd1: r = va - vb;
        3'd2: r = va & vb;
        3'd3: r = va | vb;
        3'd4: r = ~va;
        3'd5: r = ~(va & vb);
        3'd6: r = ~(va | vb);
        default: r = va ^ vb;
      endcase
      if (d[2:0] < 3'd6) begin m_rf[d[2:0]] = r; m_pc = m_pc + 8'(PC_STEP); end
      else if (d[2:0] == 3'd6) m_pc = r;
      else begin exp_q.push_back(r); m_pc = m_pc + 8'(PC_STEP); end
    end
  endtask

  // ---------------- driver tasks ----------------
  logic       tr_ov [0:511];
  logic [7:0] tr_od [0:511];
  logic [7:0] tr_pc [0:511];

  // Call in a FETCH cycle; returns at the next FETCH (or HALT) cycle.
  task automatic run_one(input logic [31:0] ins, input logic [7:0] inb,
                         output int cyc, output bit to);
    imem[m_pc] = ins;
    if (uses_input(ins)) in_q.push_back(inb);
    model_exec(ins, inb);
    cyc = 0; to = 1;
    for (int i = 0; i < MAX_CYC; i++) begin
      @(negedge clk);
      cyc++;
      tr_ov[cyc] = out_valid; tr_od[cyc] = out_data; tr_pc[cyc] = pc;
      if (imem_req || halted) begin to = 0; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 0;
    repeat (2) @(negedge clk);
    #1;
    m_pc = 0; m_halt = 0; exp_q.delete(); obs_q.delete();
    mem_lat = 0; in_delay = 0; out_delay = 0; force_valid = 0;
    rst = 1;
    #1;
  endtask

  task automatic set_reg(input int i, input logic [7:0] v);
    rf[i] = v; m_rf[i] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%0h exp=00", pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=00", out_data); end
    checks++; if (rf_wdata !== 8'h00) begin failures++; $display("FAIL reset_rf_wdata got=%0h exp=00", rf_wdata); end
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_FETCH); end
    rst = 1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL first_addr got=%0h exp=00", imem_addr); end
  endtask

  task automatic test_add();
    int cyc; bit to;
    set_reg(1, 8'd5);
    run_one(32'h02_01_03_80, 8'h00, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL add_timeout got=timeout exp=fetch"); end
    checks++; if (cyc != 3) begin failures++; $display("FAIL add_cycles got=%0d exp=3", cyc); end
    checks++; if (rf[2] !== 8'd8) begin failures++; $display("FAIL add_r2 got=%0h exp=08", rf[2]); end
    checks++; if (pc !== 8'h04) begin failures++; $display("FAIL add_pc got=%0h exp=04", pc); end
  endtask

  task automatic test_jump();
    int cyc; bit to;
    set_reg(0, 8'd9);
    run_one(32'h40_09_00_22, 8'h00, cyc, to);
    checks++; if (to || cyc != 3) begin failures++; $display("FAIL jlt_untaken_cycles got=%0d/%0b exp=3/0", cyc, to); end
    checks++; if (pc !== 8'h08) begin failures++; $display("FAIL jlt_untaken_pc got=%0h exp=08", pc); end
    set_reg(0, 8'd3);
    run_one(32'h40_09_00_22, 8'h00, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL jlt_taken_timeout got=timeout exp=fetch"); end
    checks++; if (pc !== 8'h40) begin failures++; $display("FAIL jlt_taken_pc got=%0h exp=40", pc); end
    checks++; if (rf[0] !== 8'd3) begin failures++; $display("FAIL jlt_no_write got=%0h exp=03", rf[0]); end
  endtask

  task automatic test_input_stall();
    int cyc, rc0, f0; bit to;
    rc0 = in_ready_cycles; f0 = in_fires;
    in_delay = 5;
    run_one(32'h03_07_07_00, 8'h21, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL in_timeout got=timeout exp=fetch"); end
    checks++; if (cyc != 6) begin failures++; $display("FAIL in_stall_cycles got=%0d exp=6", cyc); end
    checks++; if (in_ready_cycles - rc0 != 1) begin failures++; $display("FAIL in_ready_pulses got=%0d exp=1", in_ready_cycles - rc0); end
    checks++; if (in_fires - f0 != 1) begin failures++; $display("FAIL in_bytes got=%0d exp=1", in_fires - f0); end
    checks++; if (rf[3] !== 8'h42) begin failures++; $display("FAIL in_r3 got=%0h exp=42", rf[3]); end
    checks++; if (pc !== 8'h44) begin failures++; $display("FAIL in_pc got=%0h exp=44", pc); end
  endtask

  task automatic test_output_wait();
    int cyc, nv, nbad; bit to;
    out_delay = 4;
    run_one(32'h07_3F_3F_C0, 8'h00, cyc, to);
    nv = 0; nbad = 0;
    for (int i = 1; i <= cyc; i++) if (tr_ov[i]) begin nv++; if (tr_od[i] !== 8'h7E) nbad++; end
    checks++; if (to || cyc != 8) begin failures++; $display("FAIL out_cycles got=%0d/%0b exp=8/0", cyc, to); end
    checks++; if (nv != 5) begin failures++; $display("FAIL out_valid_cycles got=%0d exp=5", nv); end
    checks++; if (nbad != 0) begin failures++; $display("FAIL out_data_stable got=%0d bad exp=0", nbad); end
    checks++; if (cyc >= 2 && tr_pc[cyc-1] !== 8'h44) begin failures++; $display("FAIL out_pc_hold got=%0h exp=44", tr_pc[cyc-1]); end
    checks++; if (pc !== 8'h48) begin failures++; $display("FAIL out_pc_after got=%0h exp=48", pc); end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h7E) begin failures++; $display("FAIL out_byte got=%0d bytes exp=1 byte 7e", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int cyc, f0; bit to;
    logic [7:0] op, a1, a2, d, inb, got, e;
    logic [31:0] ins;
    for (int i = 0; i < 6; i++) set_reg(i, 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      op = 8'($urandom) & 8'hE7;
      a1 = op[7] ? 8'($urandom) : 8'($urandom_range(0, 7));
      a2 = op[6] ? 8'($urandom) : 8'($urandom_range(0, 7));
      d  = op[5] ? 8'($urandom) : 8'($urandom_range(0, 7));
      inb = 8'($urandom);
      ins = {d, a2, a1, op};
      mem_lat = $urandom_range(0, 2); in_delay = $urandom_range(0, 3); out_delay = $urandom_range(0, 3);
      f0 = in_fires;
      run_one(ins, inb, cyc, to);
      checks++; if (to) begin failures++; $display("FAIL rnd_timeout ins=%08h got=timeout exp=fetch", ins); end
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc ins=%08h got=%0h exp=%0h", ins, pc, m_pc); end
      for (int r = 0; r < 6; r++) begin
        checks++; if (rf[r] !== m_rf[r]) begin failures++; $display("FAIL rnd_reg r%0d ins=%08h got=%0h exp=%0h", r, ins, rf[r], m_rf[r]); end
      end
      checks++; if (in_fires - f0 != int'(uses_input(ins))) begin failures++; $display("FAIL rnd_in_bytes ins=%08h got=%0d exp=%0d", ins, in_fires - f0, uses_input(ins)); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin failures++; $display("FAIL rnd_out_missing ins=%08h got=none exp=%0h", ins, e); end
        else begin
          got = obs_q.pop_front();
          if (got !== e) begin failures++; $display("FAIL rnd_out ins=%08h got=%0h exp=%0h", ins, got, e); end
        end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rnd_out_extra ins=%08h got=%0d exp=0", ins, obs_q.size()); obs_q.delete(); end
    end
    mem_lat = 0; in_delay = 0; out_delay = 0;
  endtask

  task automatic test_wrap_halt();
    int cyc, act; bit to;
    logic [7:0] pc0;
    run_one(32'hFC_00_00_26, 8'h00, cyc, to);
    checks++; if (to || pc !== 8'hFC) begin failures++; $display("FAIL wrap_jump_pc got=%0h exp=fc", pc); end
    run_one(32'h05_02_01_C0, 8'h00, cyc, to);
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%0h exp=00", pc); end
    checks++; if (rf[5] !== 8'h03) begin failures++; $display("FAIL wrap_r5 got=%0h exp=03", rf[5]); end
    run_one(32'h0000_00FF, 8'h00, cyc, to);
    checks++; if (to || halted !== 1'b1 || cyc != 3) begin failures++; $display("FAIL halt_enter got=%0b/%0d exp=1/3", halted, cyc); end
    checks++; if (state !== ST_HALT) begin failures++; $display("FAIL halt_state got=%0d exp=%0d", state, ST_HALT); end
    pc0 = pc; act = 0;
    force_valid = 3;
    in_q.push_back(8'h55);
    repeat (8) begin
      @(negedge clk);
      if (imem_req || rf_we || in_ready || out_valid || pc !== pc0 || !halted) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL halt_ignore got=%0d active cycles exp=0", act); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL halt_pc got=%0h exp=00", pc); end
  endtask

  task automatic test_reset_out_wait();
    int cyc; bit to, seen;
    do_reset();
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL rst_recover got=%0b/%0b exp=0/1", halted, imem_req); end
    imem[0] = 32'h07_11_22_C0;
    out_delay = 1000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_ow_reach got=no out_valid exp=out_valid"); end
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_ow_out_valid got=%0b exp=0", out_valid); end
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL rst_ow_pc got=%0h exp=00", pc); end
    checks++; if (state !== ST_FETCH) begin failures++; $display("FAIL rst_ow_state got=%0d exp=%0d", state, ST_FETCH); end
    @(negedge clk); #1;
    m_pc = 0; exp_q.delete(); out_delay = 0;
    rst = 1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL rst_ow_refetch got=%0b@%0h exp=1@00", imem_req, imem_addr); end
    set_reg(4, 8'h10);
    run_one(32'h04_04_04_00, 8'h00, cyc, to);
    checks++; if (to || pc !== 8'h04 || rf[4] !== 8'h20) begin failures++; $display("FAIL rst_ow_resume got=pc %0h r4 %0h exp=pc 04 r4 20", pc, rf[4]); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_ow_lost_byte got=%0d exp=0", obs_q.size()); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; m_rf[i] = 8'h00; end
    m_pc = 0; m_halt = 0;
    test_reset();
    test_add();
    test_jump();
    test_input_stall();
    test_output_wait();
    test_random();
    test_wrap_halt();
    test_reset_out_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
